// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared state encoding, lamp patterns and default phase durations
//            for the main/side road traffic controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_SG  = 3'd3,
        ST_SY  = 3'd4,
        ST_AR2 = 3'd5,
        ST_NOC = 3'd6,
        ST_PRE = 3'd7
    } state_t;

    localparam int DEF_CW   = 8;
    localparam int DEF_T_MG = 25;
    localparam int DEF_T_Y  = 5;
    localparam int DEF_T_SG = 16;
    localparam int DEF_T_AR = 1;

    // Lamp vector packing: {mr, my, mg, cr, cy, cg}
    localparam logic [5:0] C_LAMP_MG = 6'b001_100;
    localparam logic [5:0] C_LAMP_MY = 6'b010_100;
    localparam logic [5:0] C_LAMP_AR = 6'b100_100;
    localparam logic [5:0] C_LAMP_SG = 6'b100_001;
    localparam logic [5:0] C_LAMP_SY = 6'b100_010;

    // PRE is resolved by the caller from the active emergency request.
    function automatic logic [5:0] lamps_of(input state_t s);
        logic [5:0] l;
        case (s)
            ST_MY:          l = C_LAMP_MY;
            ST_AR1, ST_AR2: l = C_LAMP_AR;
            ST_SG:          l = C_LAMP_SG;
            ST_SY:          l = C_LAMP_SY;
            default:        l = C_LAMP_MG;
        endcase
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Purpose  : Loadable CW-bit down-counter with tick enable, hold and a
//            done flag raised on the tick that finds the count at 1.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int CW   = 8,
    parameter int INIT = 1
) (
    input  logic          clk,
    input  logic          set_n,
    input  logic          i_tick,
    input  logic          i_hold,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_r_next,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nxt;

    // Count saturates at 1 so an un-reloaded phase can never wrap to zero.
    always_comb begin
        w_nxt = r_cnt;
        if (i_load) begin
            w_nxt = i_load_val;
        end else if (i_tick && !i_hold && (r_cnt > CW'(1))) begin
            w_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            r_cnt <= CW'(INIT);
        end else begin
            r_cnt <= w_nxt;
        end
    end

    assign o_r_next = w_nxt;
    assign o_done   = i_tick && (r_cnt == CW'(1));

endmodule

`default_nettype wire

// File: rtl/traffic_ctrl_p.sv
// ============================================================================
// Module   : traffic_ctrl_p
// Purpose  : Main/side road traffic light controller with side-road gap-out,
//            no-car hold on main green and emergency pre-emption.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_p
    import traffic_pkg::*;
#(
    parameter int CW   = DEF_CW,
    parameter int T_MG = DEF_T_MG,
    parameter int T_Y  = DEF_T_Y,
    parameter int T_SG = DEF_T_SG,
    parameter int T_AR = DEF_T_AR
) (
    input  logic          clk,
    input  logic          set_n,
    input  logic          tick,
    input  logic          cs,
    input  logic          em,
    input  logic          ec,
    output logic          mr,
    output logic          my,
    output logic          mg,
    output logic          cr,
    output logic          cy,
    output logic          cg,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_c,
    output logic [2:0]    phase
);

    localparam int C_TMAX = (2 ** CW) - 1;

    generate
        if (T_MG < 1 || T_MG > C_TMAX || T_Y < 1 || T_Y > C_TMAX ||
            T_SG < 1 || T_SG > C_TMAX || T_AR < 1 || T_AR > C_TMAX) begin : g_bad_duration
            $error("traffic_ctrl_p: every T_* duration must lie in 1..2**CW-1");
        end
    endgenerate

    localparam logic [CW-1:0] C_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] C_LD_MG = CW'(T_MG);
    localparam logic [CW-1:0] C_LD_Y  = CW'(T_Y);
    localparam logic [CW-1:0] C_LD_SG = CW'(T_SG);
    localparam logic [CW-1:0] C_LD_AR = CW'(T_AR);

    localparam logic [CW+1:0] C_W_MG = (CW+2)'(T_MG);
    localparam logic [CW+1:0] C_W_Y  = (CW+2)'(T_Y);
    localparam logic [CW+1:0] C_W_SG = (CW+2)'(T_SG);
    localparam logic [CW+1:0] C_W_AR = (CW+2)'(T_AR);

    localparam int            C_RST_SUM  = T_MG + T_Y + T_AR;
    localparam logic [CW-1:0] C_RST_CNTC = (C_RST_SUM > C_TMAX) ? C_MAX : CW'(C_RST_SUM);

    function automatic logic [CW-1:0] sat(input logic [CW+1:0] v);
        return (v > {2'b00, C_MAX}) ? C_MAX : v[CW-1:0];
    endfunction

    state_t        r_state;
    logic [5:0]    r_lamps;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_count_c;

    state_t        w_nxt_state;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_hold;
    logic          w_done;
    logic [CW-1:0] w_r_next;
    logic [CW+1:0] w_rn;
    logic [5:0]    w_lamps;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_c;

    phase_timer #(
        .CW   (CW),
        .INIT (T_MG)
    ) u_timer (
        .clk        (clk),
        .set_n      (set_n),
        .i_tick     (tick),
        .i_hold     (w_hold),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_r_next   (w_r_next),
        .o_done     (w_done)
    );

    // Emergency requests override every other rule, tick or not.
    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_load_val  = C_LD_MG;
        w_hold      = 1'b0;
        if (em || ec) begin
            w_nxt_state = ST_PRE;
            w_hold      = 1'b1;
        end else begin
            case (r_state)
                ST_MG: begin
                    if (w_done) begin
                        if (cs) begin
                            w_nxt_state = ST_MY;
                            w_load      = 1'b1;
                            w_load_val  = C_LD_Y;
                        end else begin
                            w_nxt_state = ST_NOC;
                        end
                    end
                end
                ST_MY: begin
                    if (w_done) begin
                        w_nxt_state = ST_AR1;
                        w_load      = 1'b1;
                        w_load_val  = C_LD_AR;
                    end
                end
                ST_AR1: begin
                    if (w_done) begin
                        w_nxt_state = ST_SG;
                        w_load      = 1'b1;
                        w_load_val  = C_LD_SG;
                    end
                end
                ST_SG: begin
                    if (w_done || (tick && !cs)) begin
                        w_nxt_state = ST_SY;
                        w_load      = 1'b1;
                        w_load_val  = C_LD_Y;
                    end
                end
                ST_SY: begin
                    if (w_done) begin
                        w_nxt_state = ST_AR2;
                        w_load      = 1'b1;
                        w_load_val  = C_LD_AR;
                    end
                end
                ST_AR2: begin
                    if (w_done) begin
                        w_nxt_state = ST_MG;
                        w_load      = 1'b1;
                        w_load_val  = C_LD_MG;
                    end
                end
                ST_NOC: begin
                    w_hold = 1'b1;
                    if (tick && cs) begin
                        w_nxt_state = ST_MG;
                        w_load      = 1'b1;
                        w_load_val  = C_LD_MG;
                    end
                end
                ST_PRE: begin
                    w_nxt_state = ST_AR2;
                    w_load      = 1'b1;
                    w_load_val  = C_LD_AR;
                end
                default: begin
                    w_nxt_state = ST_MG;
                    w_load      = 1'b1;
                    w_load_val  = C_LD_MG;
                end
            endcase
        end
    end

    // Countdowns are built from the timer's next value so they line up with
    // the registered state and lamps.
    always_comb begin
        w_rn      = {2'b00, w_r_next};
        w_lamps   = lamps_of(w_nxt_state);
        w_count   = '0;
        w_count_c = '0;
        if (em || ec) begin
            w_lamps = em ? C_LAMP_MG : C_LAMP_SG;
        end
        case (w_nxt_state)
            ST_MG: begin
                w_count   = sat(w_rn);
                w_count_c = sat(w_rn + C_W_Y + C_W_AR);
            end
            ST_MY: begin
                w_count   = sat(w_rn);
                w_count_c = sat(w_rn + C_W_AR);
            end
            ST_AR1: begin
                w_count   = sat(w_rn + C_W_SG + C_W_Y + C_W_AR);
                w_count_c = sat(w_rn);
            end
            ST_SG: begin
                w_count   = sat(w_rn + C_W_Y + C_W_AR);
                w_count_c = sat(w_rn);
            end
            ST_SY: begin
                w_count   = sat(w_rn + C_W_AR);
                w_count_c = sat(w_rn);
            end
            ST_AR2: begin
                w_count   = sat(w_rn);
                w_count_c = sat(w_rn + C_W_MG + C_W_Y + C_W_AR);
            end
            ST_NOC: begin
                w_count   = '0;
                w_count_c = C_MAX;
            end
            default: begin
                w_count   = '0;
                w_count_c = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            r_state   <= ST_MG;
            r_lamps   <= C_LAMP_MG;
            r_count   <= C_LD_MG;
            r_count_c <= C_RST_CNTC;
        end else begin
            r_state   <= w_nxt_state;
            r_lamps   <= w_lamps;
            r_count   <= w_count;
            r_count_c <= w_count_c;
        end
    end

    assign {mr, my, mg, cr, cy, cg} = r_lamps;
    assign count   = r_count;
    assign count_c = r_count_c;
    assign phase   = r_state;

endmodule

`default_nettype wire

// File: doc/traffic_ctrl_p.md
TRAFFIC_CTRL_P -- requirements
Module: traffic_ctrl_p

Interface
REQ-001 Parameter CW, default 8: width of the countdown outputs and of the internal phase timer.
REQ-002 Parameter T_MG, default 25: main green minimum duration, in ticks.
REQ-003 Parameter T_Y, default 5: yellow duration in ticks, used on both roads.
REQ-004 Parameter T_SG, default 16: side green maximum duration, in ticks.
REQ-005 Parameter T_AR, default 1: all-red clearance duration, in ticks.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port set_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 Port tick, input, 1 bit: one-cycle pulse that marks one second.
REQ-009 Port cs, input, 1 bit: side-road vehicle present.
REQ-010 Port em, input, 1 bit: main-road emergency request.
REQ-011 Port ec, input, 1 bit: side-road emergency request.
REQ-012 Ports mr, my, mg, output, 1 bit each: main-road red, yellow and green lamps.
REQ-013 Ports cr, cy, cg, output, 1 bit each: side-road red, yellow and green lamps.
REQ-014 Port count, output, CW bits: ticks until the main lamp next changes colour.
REQ-015 Port count_c, output, CW bits: ticks until the side lamp next changes colour.
REQ-016 Port phase, output, 3 bits: current state encoding.

Function
REQ-017 The state set SHALL be MG, MY, AR1, SG, SY, AR2, NOC and PRE.
- Lamps: MG = mg+cr; MY = my+cr; AR1 and AR2 = mr+cr; SG = mr+cg; SY = mr+cy; NOC = mg+cr; PRE is set by REQ-024.
REQ-018 The phase timer r SHALL decrement only on a cycle with tick=1; a phase ends on the tick at which r==1.
REQ-019 At the end of a phase, state and lamps SHALL change on the same clock edge, and r SHALL load the next phase's duration on that edge.
- All outputs are registered; there is no combinational path from any input to any output.
REQ-020 MG at end: if cs=1, go to MY (r=T_Y); if cs=0, go to NOC.
- Then MY goes to AR1 (r=T_AR), AR1 goes to SG (r=T_SG), SY goes to AR2 (r=T_AR), and AR2 goes to MG (r=T_MG).
REQ-021 SG gap-out: on any tick in SG with cs=0, the block SHALL go to SY (r=T_Y) without waiting for r to expire.
REQ-022 NOC: r is held; count=0 and count_c=all-ones.
- On the first tick with cs=1, go to MG with r=T_MG.
REQ-023 Countdowns outside NOC and PRE, computed and then saturated at 2^CW-1:
- MG: count=r, count_c=r+T_Y+T_AR.
- MY: count=r, count_c=r+T_AR.
- AR1: count=r+T_SG+T_Y+T_AR, count_c=r.
- SG: count=r+T_Y+T_AR, count_c=r.
- SY: count=r+T_AR, count_c=r.
- AR2: count=r, count_c=r+T_MG+T_Y+T_AR.
REQ-024 On any cycle with em=1 or ec=1, the next edge SHALL enter PRE, independent of tick.
- em has priority over ec.
- Lamps: em gives mg+cr; ec alone gives mr+cg.
- count=count_c=0 while in PRE.
REQ-025 When em and ec both return to 0, the block SHALL go to AR2 (r=T_AR) and then to MG.
- If the request switches between em and ec during PRE, the lamps SHALL follow on the next edge.
REQ-026 Exactly one lamp per road SHALL be on in every state, and mg/cg SHALL never both be 1.
REQ-027 The timer arithmetic SHALL be CW bits wide and SHALL never wrap below 1.
- Each T_* parameter SHALL be in the range 1 to 2^CW-1; an elaboration-time check SHALL reject any other value.

Reset
REQ-028 While set_n=0, the block SHALL hold the following, with no clock edge required:
- state=MG, r=T_MG;
- mg=cr=1, all other lamps 0;
- count=T_MG, count_c=T_MG+T_Y+T_AR.
REQ-029 Deasserting set_n in the middle of any phase (including PRE) SHALL restart the block from the REQ-028 state.
- The first decrement SHALL happen on the first tick after deassertion.

Structure
REQ-030 A shared package traffic_pkg SHALL hold the state enum and encodings, the lamp-pattern constants and the default durations.
REQ-031 One sub-module, phase_timer, SHALL provide a CW-bit loadable down-counter with a tick enable, a hold input and a done flag (r==1 && tick).

Verification
REQ-032 The bench SHALL cover at least these directed scenarios (default parameters, tick=1 every 4 cycles):
- cs=1 held: phases MG 25, MY 5, AR1 1, SG 16, SY 5, AR2 1 ticks; count reads 25 and count_c reads 31 just after reset.
- cs=0 from reset: after 25 ticks, enter NOC with count=0 and count_c=255; raise cs, and on the next tick go to MG with count=25.
- cs dropped at tick 3 of SG: SY on that edge with count_c=5, then AR2, then MG.
- em pulse during SY: next edge gives PRE with mg=1, cr=1 and counts 0; after release, 1 tick of AR2 then MG with r=25. em and ec together give main green.
- set_n low for 2 cycles mid-SG: lamps return to mg/cr immediately and asynchronously; count=25.
- T_MG=300 with CW=8 is rejected at elaboration; a lamp-exclusivity assertion runs through all scenarios.
